// File: rtl/dpr_port_driver_pkg.sv
// dpr_port_driver shared types: command opcodes, FSM states,
// response buffer sizing and the credit-count helper.
package dpr_port_driver_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FILL  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam int unsigned RSP_DEPTH = 2;

  localparam logic [2:0] CREDIT_MAX = 3'(RSP_DEPTH);

  function automatic logic [2:0] credit_sum(
    input logic       rd_issue,
    input logic       rd_return,
    input logic [1:0] buf_cnt
  );
    return 3'(rd_issue) + 3'(rd_return) + 3'(buf_cnt);
  endfunction

endpackage

// File: rtl/dpr_rsp_fifo.sv
// Two-entry response buffer holding {data, addr}; the head entry
// sits in a dedicated register so its outputs come straight off flops.
module dpr_rsp_fifo
  import dpr_port_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [1:0]            count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [1:0] FULL_CNT = 2'(RSP_DEPTH);

  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
  logic [DATA_WIDTH-1:0] spare_data_q, spare_data_d;
  logic [ADDR_WIDTH-1:0] spare_addr_q, spare_addr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;

  assign head_data = head_data_q;
  assign head_addr = head_addr_q;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    head_data_d  = head_data_q;
    head_addr_d  = head_addr_q;
    spare_data_d = spare_data_q;
    spare_addr_d = spare_addr_q;
    cnt_d        = cnt_q;
    case ({do_push, do_pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (empty) begin
          head_data_d = push_data;
          head_addr_d = push_addr;
        end else begin
          spare_data_d = push_data;
          spare_addr_d = push_addr;
        end
      end
      2'b01: begin
        cnt_d       = cnt_q - 2'd1;
        head_data_d = spare_data_q;
        head_addr_d = spare_addr_q;
      end
      2'b11: begin
        // occupancy unchanged; new entry lands behind the survivor
        if (cnt_q == 2'd1) begin
          head_data_d = push_data;
          head_addr_d = push_addr;
        end else begin
          head_data_d  = spare_data_q;
          head_addr_d  = spare_addr_q;
          spare_data_d = push_data;
          spare_addr_d = push_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_q  <= '0;
      head_addr_q  <= '0;
      spare_data_q <= '0;
      spare_addr_q <= '0;
      cnt_q        <= '0;
    end else begin
      head_data_q  <= head_data_d;
      head_addr_q  <= head_addr_d;
      spare_data_q <= spare_data_d;
      spare_addr_q <= spare_addr_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: rtl/dpr_port_driver.sv
// Command front-end for one port of the dual-port RAM: read, write
// and autonomous fill, with credited read responses.
module dpr_port_driver
  import dpr_port_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  rd1_q, rd1_d;
  logic                  rd2_q, rd2_d;
  logic [ADDR_WIDTH-1:0] rd2_addr_q, rd2_addr_d;

  op_e                   op;
  logic                  accept;
  logic [2:0]            credits;
  logic                  bypass;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [1:0]            fifo_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign op = op_e'(cmd_op);

  // rd1: address on the RAM port; rd2: mem_q carries the data
  assign credits = credit_sum(rd1_q, rd2_q, fifo_cnt);

  assign cmd_ready = (state_q == ST_IDLE)
                  && (credits < CREDIT_MAX)
                  && !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q == ST_FILL) || (credits != 3'd0);

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;

  // returning word skips the buffer when nothing is queued ahead
  assign bypass    = rd2_q && fifo_empty;
  assign rsp_valid = rd2_q || !fifo_empty;
  assign rsp_data  = bypass ? mem_q : head_data;
  assign rsp_addr  = bypass ? rd2_addr_q : head_addr;

  assign fifo_pop  = !fifo_empty && rsp_ready;
  assign fifo_push = rd2_q && !(bypass && rsp_ready);

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    rem_d      = rem_q;
    rd1_d      = 1'b0;
    rd2_d      = rd1_q;
    rd2_addr_d = rd1_q ? mem_addr_q : rd2_addr_q;
    if (state_q == ST_FILL) begin
      if (rem_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        mem_we_d   = 1'b1;
        mem_addr_d = mem_addr_q + 1'b1;
        rem_d      = rem_q - 1'b1;
      end
    end else if (accept) begin
      unique case (1'b1)
        (op == OP_READ): begin
          mem_addr_d = cmd_addr;
          rd1_d      = 1'b1;
        end
        (op == OP_WRITE): begin
          mem_addr_d = cmd_addr;
          mem_data_d = cmd_data;
          mem_we_d   = 1'b1;
        end
        (op == OP_FILL): begin
          mem_addr_d = cmd_addr;
          mem_data_d = cmd_data;
          mem_we_d   = 1'b1;
          rem_d      = cmd_len;
          state_d    = ST_FILL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      rem_q      <= '0;
      rd1_q      <= 1'b0;
      rd2_q      <= 1'b0;
      rd2_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      rem_q      <= rem_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      rd2_addr_q <= rd2_addr_d;
    end
  end

  dpr_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mem_q),
    .push_addr (rd2_addr_q),
    .pop       (fifo_pop),
    .head_data (head_data),
    .head_addr (head_addr),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_dpr_port_driver.sv
// Bench for dpr_port_driver: driver wired to a write-first RAM port,
// checked against a command-level memory and response model.
module tb_dpr_port_driver;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  typedef struct {
    logic [7:0] d;
    logic [7:0] a;
    int         cyc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [AW-1:0] cmd_len;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic [DW-1:0] mem_q;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          busy;

  logic          ld;
  logic          rnd_mode;
  logic          rr_dir;
  logic          rr_rnd;

  logic [7:0]    ram  [DEPTH];
  logic [7:0]    gold [DEPTH];
  ent_t          exp_q[$];
  ent_t          obs_q[$];
  int            cyc;
  int            we_cnt;
  int            acc_cnt;
  int            n_chk;
  int            n_err;
  int            scored;

  always #5 clk = ~clk;

  assign rsp_ready = rnd_mode ? rr_rnd : rr_dir;

  dpr_port_driver #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_q     (mem_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .busy      (busy)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // RAM port: registered read, write-first
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_data;
    end
    mem_q <= mem_we ? mem_data : ram[mem_addr];
  end

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rr_rnd <= ($urandom % 4) != 0;
  end

  // command-level model: commands take effect in accept order
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) gold[i] = ram[i];
    end else begin
      if (mem_we) we_cnt++;
      if (cmd_valid && cmd_ready) begin
        acc_cnt++;
        case (cmd_op)
          2'd0: exp_q.push_back('{gold[cmd_addr], cmd_addr, cyc});
          2'd1: gold[cmd_addr] = cmd_data;
          2'd2: begin
            for (int i = 0; i <= int'(cmd_len); i++) begin
              logic [7:0] ix;
              ix = cmd_addr + 8'(i);
              gold[ix] = cmd_data;
            end
          end
          default: ;
        endcase
      end
      if (rsp_valid && rsp_ready)
        obs_q.push_back('{rsp_data, rsp_addr, cyc});
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] l);
    int t;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_len   = l;
    cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 600) begin
      t++;
      @(negedge clk);
    end
    if (t >= 600) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (t >= 2000) check("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic score();
    while (scored < obs_q.size()) begin
      if (scored < exp_q.size()) begin
        check("rsp_data", obs_q[scored].d, exp_q[scored].d);
        check("rsp_addr", obs_q[scored].a, exp_q[scored].a);
      end else begin
        check("rsp_extra", 1, 0);
      end
      scored++;
    end
  endtask

  initial begin
    int n, bad, w0, r0, a0, idx, t;
    logic [7:0] snap [8];
    rst = 1'b1; ld = 1'b1; rnd_mode = 1'b0; rr_dir = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_data = '0; cmd_len = '0;
    cyc = 0; we_cnt = 0; acc_cnt = 0;
    n_chk = 0; n_err = 0; scored = 0;

    repeat (3) @(posedge clk);
    #1 ld = 1'b0;
    @(negedge clk);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_rsp", {rsp_valid, rsp_data, rsp_addr}, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_ready", cmd_ready, 1);
    @(posedge clk);
    #1;

    // write then read the same word on the next cycle
    send(2'd1, 8'h20, 8'h5A, 8'h00);
    send(2'd0, 8'h20, 8'h00, 8'h00);
    wait_idle();
    idx = exp_q.size() - 1;
    check("raw_obs", obs_q.size(), exp_q.size());
    if (idx >= 0 && obs_q.size() > idx) begin
      check("raw_data", obs_q[idx].d, 8'h5A);
      check("raw_addr", obs_q[idx].a, 8'h20);
      check("raw_lat", obs_q[idx].cyc - exp_q[idx].cyc, 2);
    end
    score();

    // wrapping fill
    send(2'd2, 8'hFD, 8'hFE, 8'd3);
    n = 0; bad = 0;
    @(negedge clk);
    while (mem_we && n < 300) begin
      n++;
      if (cmd_ready) bad++;
      @(negedge clk);
    end
    check("fill_len", n, 4);
    check("fill_rdy_low", bad, 0);
    check("fill_rdy_back", cmd_ready, 1);
    @(posedge clk);
    #1;
    r0 = obs_q.size();
    send(2'd0, 8'hFD, 8'h00, 8'h00);
    send(2'd0, 8'hFE, 8'h00, 8'h00);
    send(2'd0, 8'hFF, 8'h00, 8'h00);
    send(2'd0, 8'h00, 8'h00, 8'h00);
    send(2'd0, 8'h01, 8'h00, 8'h00);
    wait_idle();
    check("wrap_cnt", obs_q.size() - r0, 5);
    if (obs_q.size() >= r0 + 4)
      for (int i = 0; i < 4; i++)
        check("wrap_val", obs_q[r0+i].d, 8'hFE);
    check("wrap_untouched", ram[1], init_val(1));
    score();

    // backpressure: two credits, then stall until a pop
    @(posedge clk);
    #1 rr_dir = 1'b0;
    a0 = acc_cnt;
    r0 = obs_q.size();
    send(2'd0, 8'h40, 8'h00, 8'h00);
    send(2'd0, 8'h41, 8'h00, 8'h00);
    cmd_op = 2'd0; cmd_addr = 8'h42; cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_acc", acc_cnt - a0, 2);
    check("bp_rdy", cmd_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_rv", rsp_valid, 1);
    @(posedge clk);
    #1 rr_dir = 1'b1;
    @(negedge clk);
    check("bp_pop_rdy", cmd_ready, 0);
    @(negedge clk);
    check("bp_after_pop", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    send(2'd0, 8'h43, 8'h00, 8'h00);
    wait_idle();
    check("bp_cnt", obs_q.size() - r0, 4);
    if (obs_q.size() >= r0 + 4)
      for (int i = 0; i < 4; i++)
        check("bp_order", obs_q[r0+i].a, 8'h40 + 8'(i));
    score();

    // stream reads after a fill
    send(2'd2, 8'h00, 8'h33, 8'd15);
    wait_idle();
    r0 = obs_q.size();
    for (int i = 0; i < 16; i++) send(2'd0, 8'(i), 8'h00, 8'h00);
    wait_idle();
    check("str_cnt", obs_q.size() - r0, 16);
    if (obs_q.size() >= r0 + 16)
      for (int i = 0; i < 16; i++) begin
        check("str_val", obs_q[r0+i].d, 8'h33);
        check("str_addr", obs_q[r0+i].a, 8'(i));
      end
    score();

    // reserved opcode between two writes
    w0 = we_cnt;
    r0 = obs_q.size();
    send(2'd1, 8'h50, 8'h11, 8'h00);
    send(2'd3, 8'h51, 8'h22, 8'h00);
    send(2'd1, 8'h52, 8'h33, 8'h00);
    wait_idle();
    check("rsvd_we", we_cnt - w0, 2);
    check("rsvd_rsp", obs_q.size() - r0, 0);
    check("rsvd_mem", ram[8'h51], init_val(8'h51));

    // full-range fill touches every address once
    w0 = we_cnt;
    send(2'd2, 8'h80, 8'h6C, 8'hFF);
    wait_idle();
    check("full_we", we_cnt - w0, 256);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 8'h6C) bad++;
    check("full_mem", bad, 0);

    // reset in the middle of a fill
    for (int i = 0; i < 8; i++) snap[i] = ram[8'h10 + 8'(i)];
    send(2'd2, 8'h10, 8'hC3, 8'd7);
    n = 0; t = 0;
    while (n < 3 && t < 50) begin
      @(negedge clk);
      if (mem_we) n++;
      t++;
    end
    check("mf_reach", n, 3);
    rst = 1'b1;
    #1;
    check("mf_we", mem_we, 0);
    check("mf_addr", mem_addr, 0);
    check("mf_busy", busy, 0);
    check("mf_rv", rsp_valid, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mf_rdy", cmd_ready, 1);
    check("mf_w10", ram[8'h10], 8'hC3);
    check("mf_w11", ram[8'h11], 8'hC3);
    bad = 0;
    for (int i = 3; i < 8; i++)
      if (ram[8'h10 + 8'(i)] !== snap[i]) bad++;
    check("mf_keep", bad, 0);
    @(posedge clk);
    #1;

    // random traffic with random response backpressure
    rnd_mode = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
      send(2'($urandom % 4), 8'($urandom), 8'($urandom),
           8'($urandom % 8));
    end
    wait_idle();
    rnd_mode = 1'b0;
    score();
    check("rsp_total", obs_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== gold[i]) bad++;
    check("ram_model", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
